// File: rtl/lcd_pkg.sv
// lcd_pkg
//   Shared types and constants for the 8080-style LCD bus writer.
//   - lcd_state_e : write-cycle FSM states
//   - CNT_W       : phase counter width (covers phase lengths up to 255)
//   - lcd_entry_t : one buffered byte with its data/command select
//   - phase_load  : converts a phase length in clocks to a counter load value
package lcd_pkg;

   localparam int unsigned CNT_W = $clog2(256);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } lcd_state_e;

   typedef struct packed {
      logic       dc;
      logic [7:0] data;
   } lcd_entry_t;

   // The counter is loaded with N-1 and the phase ends on the clock where it
   // reads zero, so a phase lasts exactly N clocks and the counter never wraps.
   function automatic logic [CNT_W-1:0] phase_load(input int unsigned clocks);
      return CNT_W'(clocks - 1);
   endfunction

endpackage

// File: rtl/lcd_byte_fifo.sv
// lcd_byte_fifo
//   Synchronous show-ahead FIFO of lcd_entry_t. head_o always shows the oldest
//   entry while empty_o is low; pop_i consumes it on the clock edge.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset (pointers/count)
//     push_i, wdata_i : write request and entry
//     pop_i           : consume head entry
//     head_o          : oldest entry (valid when !empty_o)
//     full_o, empty_o : occupancy flags
//     count_o         : number of stored entries (0..DEPTH)
//   DEPTH must be a power of two (pointers wrap naturally).
module lcd_byte_fifo
   import lcd_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  lcd_entry_t             wdata_i,
   input  logic                   pop_i,
   output lcd_entry_t             head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   lcd_entry_t    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A pop on empty is ignored; a push on full is accepted only when the same
   // clock frees a slot, so simultaneous push/pop never loses an entry.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer
//   Buffers bytes from an Avalon-ST sink and writes them to an 8080-style
//   parallel LCD bus. Each byte is a SETUP / STROBE / HOLD sequence of
//   WR_SETUP + WR_LOW + WR_HIGH clocks; chip select stays low across
//   back-to-back bytes.
//   Parameters:
//     FIFO_DEPTH : byte buffer entries (power of two, 2..64)
//     WR_SETUP   : clocks cs low, wr high, data stable before the wr fall
//     WR_LOW     : clocks wr low
//     WR_HIGH    : clocks wr high after the rise, data held
//   Ports:
//     clk, reset             : clock, synchronous active-high reset
//     in_valid/in_data/in_channel/in_ready : sink (channel 0 cmd, 1 data)
//     lcd_cs_n, lcd_wr_n, lcd_dc, lcd_data : registered panel bus
//     lcd_busy               : FIFO non-empty or a write in progress
//     overflow               : sticky dropped-byte flag, present only when
//                              LCD_BUS_WRITER_OVERFLOW_FLAG_EN is defined
module lcd_bus_writer
   import lcd_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned WR_SETUP   = 2,
   parameter int unsigned WR_LOW     = 3,
   parameter int unsigned WR_HIGH    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_channel,
   output logic       in_ready,
   output logic       lcd_cs_n,
   output logic       lcd_wr_n,
   output logic       lcd_dc,
   output logic [7:0] lcd_data,
   output logic       lcd_busy
`ifdef LCD_BUS_WRITER_OVERFLOW_FLAG_EN
   ,
   output logic       overflow
`endif
);

   localparam logic [CNT_W-1:0] SETUP_LD = phase_load(WR_SETUP);
   localparam logic [CNT_W-1:0] LOW_LD   = phase_load(WR_LOW);
   localparam logic [CNT_W-1:0] HIGH_LD  = phase_load(WR_HIGH);

   lcd_state_e                    state_q;
   logic [CNT_W-1:0]              cnt_q;
   logic                          cs_n_q, wr_n_q, dc_q;
   logic [7:0]                    data_q;

   lcd_entry_t                    fifo_wdata, fifo_head;
   logic                          fifo_push, fifo_pop;
   logic                          fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic                          phase_done;

   // ---------------------------------------------------------------- sink
   assign in_ready   = !fifo_full && !reset;
   assign fifo_push  = in_valid && in_ready;
   assign fifo_wdata = '{dc: in_channel, data: in_data};

   lcd_byte_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // ---------------------------------------------------------------- FSM
   assign phase_done = (cnt_q == '0);

   // The head is consumed on exactly the edge that loads it into the bus
   // registers: from IDLE, or at the end of HOLD for back-to-back writes.
   assign fifo_pop = !fifo_empty &&
                     ((state_q == ST_IDLE) || (state_q == ST_HOLD && phase_done));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cs_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         dc_q    <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state_q <= ST_SETUP;
                  cnt_q   <= SETUP_LD;
                  cs_n_q  <= 1'b0;
                  wr_n_q  <= 1'b1;
                  dc_q    <= fifo_head.dc;
                  data_q  <= fifo_head.data;
               end
            end
            ST_SETUP: begin
               if (phase_done) begin
                  state_q <= ST_STROBE;
                  cnt_q   <= LOW_LD;
                  wr_n_q  <= 1'b0;
               end else begin
                  cnt_q   <= cnt_q - 1'b1;
               end
            end
            ST_STROBE: begin
               if (phase_done) begin
                  state_q <= ST_HOLD;
                  cnt_q   <= HIGH_LD;
                  wr_n_q  <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q - 1'b1;
               end
            end
            ST_HOLD: begin
               if (phase_done) begin
                  if (!fifo_empty) begin
                     // Next byte: cs stays low, bus changes only here.
                     state_q <= ST_SETUP;
                     cnt_q   <= SETUP_LD;
                     dc_q    <= fifo_head.dc;
                     data_q  <= fifo_head.data;
                  end else begin
                     state_q <= ST_IDLE;
                     cs_n_q  <= 1'b1;
                  end
               end else begin
                  cnt_q   <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cs_n_q  <= 1'b1;
               wr_n_q  <= 1'b1;
            end
         endcase
      end
   end

   assign lcd_cs_n = cs_n_q;
   assign lcd_wr_n = wr_n_q;
   assign lcd_dc   = dc_q;
   assign lcd_data = data_q;
   assign lcd_busy = !reset && ((fifo_count != '0) || (state_q != ST_IDLE));

   // ---------------------------------------------------------------- overflow
`ifdef LCD_BUS_WRITER_OVERFLOW_FLAG_EN
   logic overflow_q;

   always_ff @(posedge clk) begin
      if (reset)                      overflow_q <= 1'b0;
      else if (in_valid && !in_ready) overflow_q <= 1'b1;
   end

   assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_lcd_bus_writer.sv
module tb_lcd_bus_writer;
   import lcd_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // default instance
   logic       in_valid, in_channel, in_ready;
   logic [7:0] in_data;
   logic       cs_n, wr_n, dc, busy;
   logic [7:0] data;
   // minimum-timing instance
   logic       mn_valid, mn_ready, mn_cs, mn_wr, mn_dc, mn_busy;
   logic [7:0] mn_data_i, mn_data;
   // maximum-timing instance
   logic       mx_valid, mx_ready, mx_cs, mx_wr, mx_dc, mx_busy;
   logic [7:0] mx_data_i, mx_data;
`ifdef LCD_BUS_WRITER_OVERFLOW_FLAG_EN
   logic       ovf, mn_ovf, mx_ovf;
`endif

   lcd_bus_writer dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_channel(in_channel), .in_ready(in_ready), .lcd_cs_n(cs_n),
      .lcd_wr_n(wr_n), .lcd_dc(dc), .lcd_data(data), .lcd_busy(busy)
`ifdef LCD_BUS_WRITER_OVERFLOW_FLAG_EN
      , .overflow(ovf)
`endif
   );

   lcd_bus_writer #(.WR_SETUP(1), .WR_LOW(1), .WR_HIGH(1)) dut_min (
      .clk(clk), .reset(reset), .in_valid(mn_valid), .in_data(mn_data_i),
      .in_channel(1'b0), .in_ready(mn_ready), .lcd_cs_n(mn_cs),
      .lcd_wr_n(mn_wr), .lcd_dc(mn_dc), .lcd_data(mn_data), .lcd_busy(mn_busy)
`ifdef LCD_BUS_WRITER_OVERFLOW_FLAG_EN
      , .overflow(mn_ovf)
`endif
   );

   lcd_bus_writer #(.WR_SETUP(255), .WR_LOW(255), .WR_HIGH(255)) dut_max (
      .clk(clk), .reset(reset), .in_valid(mx_valid), .in_data(mx_data_i),
      .in_channel(1'b1), .in_ready(mx_ready), .lcd_cs_n(mx_cs),
      .lcd_wr_n(mx_wr), .lcd_dc(mx_dc), .lcd_data(mx_data), .lcd_busy(mx_busy)
`ifdef LCD_BUS_WRITER_OVERFLOW_FLAG_EN
      , .overflow(mx_ovf)
`endif
   );

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // bus monitor: one record per wr_n rise while cs_n is low
   typedef struct {
      logic       dc;
      logic [7:0] data;
      int         cyc;
   } wr_rec_t;

   wr_rec_t q[$];
   int      cyc = 0;
   int      cs_rise = 0;
   logic    wr_pv = 1'b1, cs_pv = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!wr_pv && wr_n && !cs_n) q.push_back('{dc: dc, data: data, cyc: cyc});
      if (!cs_pv && cs_n) cs_rise <= cs_rise + 1;
      wr_pv <= wr_n;
      cs_pv <= cs_n;
   end

   task automatic wait_idle(input string tag, input int lim);
      int n = 0;
      while (busy && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] cs_tr, wr_tr;
      logic       hold_ok;
      logic [11:0] rdy;
      int         r0, n, lo_cs, lo_wr;

      reset = 1'b1;
      in_valid = 1'b0; in_data = 8'h00; in_channel = 1'b0;
      mn_valid = 1'b0; mn_data_i = 8'h00;
      mx_valid = 1'b0; mx_data_i = 8'h00;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_cs", cs_n, 1'b1);
      chk("rst_wr", wr_n, 1'b1);
      chk("rst_dc", dc, 1'b0);
      chk("rst_data", data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rdy", in_ready, 1'b0);
      reset = 1'b0;
      #1;
      chk("rdy_up", in_ready, 1'b1);
`ifdef LCD_BUS_WRITER_OVERFLOW_FLAG_EN
      chk("ovf_rst", ovf, 1'b0);
`endif

      // single command write 0x2C
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h2C; in_channel = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("sw_cs0", cs_n, 1'b1);
      chk("sw_busy0", busy, 1'b1);
      cs_tr = '0; wr_tr = '0; hold_ok = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         cs_tr[k-1] = cs_n;
         wr_tr[k-1] = wr_n;
         if (k <= 7 && (data !== 8'h2C || dc !== 1'b0)) hold_ok = 1'b0;
      end
      chk("sw_cs_tr", cs_tr, 8'h80);
      chk("sw_wr_tr", wr_tr, 8'hE3);
      chk("sw_hold", hold_ok, 1'b1);
      chk("sw_busy", busy, 1'b0);
      chk("sw_cnt", q.size(), 1);
      chk("sw_byte", q[0].data, 8'h2C);
      q.delete();

      // burst 0x01..0x08, data channel
      r0 = cs_rise;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = 8'(i); in_channel = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_idle("bu_idle", 120);
      chk("bu_cnt", q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("bu_data%0d", i), q[i].data, 8'(i + 1));
         chk($sformatf("bu_dc%0d", i), q[i].dc, 1'b1);
         if (i > 0) chk($sformatf("bu_gap%0d", i), q[i].cyc - q[i-1].cyc, 7);
      end
      chk("bu_cs_gap", cs_rise - r0, 1);
      q.delete();

      // overflow: 12 back-to-back pushes, 10 fit (one pop at start, one at byte end)
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1; in_data = 8'(8'h10 + i); in_channel = i[0];
         rdy[i] = in_ready;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("ov_rdy9", rdy[9], 1'b1);
      chk("ov_rdy10", rdy[10], 1'b0);
      chk("ov_rdy11", rdy[11], 1'b0);
`ifdef LCD_BUS_WRITER_OVERFLOW_FLAG_EN
      chk("ov_flag", ovf, 1'b1);
`endif
      wait_idle("ov_idle", 150);
      chk("ov_cnt", q.size(), 10);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("ov_data%0d", i), q[i].data, 8'(8'h10 + i));
         chk($sformatf("ov_dc%0d", i), q[i].dc, i[0]);
      end
      q.delete();

      // reset during STROBE
      in_valid = 1'b1; in_data = 8'h55; in_channel = 1'b0;
      @(negedge clk);
      in_data = 8'h66;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (wr_n && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rs_strobe", wr_n, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk("rs_wr", wr_n, 1'b1);
      chk("rs_cs", cs_n, 1'b1);
      reset = 1'b0;
      #1;
      chk("rs_busy", busy, 1'b0);
`ifdef LCD_BUS_WRITER_OVERFLOW_FLAG_EN
      chk("rs_ovf", ovf, 1'b0);
`endif
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hA7; in_channel = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle("rs_idle", 40);
      chk("rs_cnt", q.size(), 1);
      chk("rs_data", q[0].data, 8'hA7);
      chk("rs_dc", q[0].dc, 1'b1);
      q.delete();

      // minimum timing: 3-clock write, 1 clock strobe
      mn_valid = 1'b1; mn_data_i = 8'h5A;
      @(negedge clk);
      mn_valid = 1'b0;
      n = 0;
      while (mn_cs && n < 5) begin
         @(negedge clk);
         n++;
      end
      lo_cs = 0; lo_wr = 0;
      while (!mn_cs && lo_cs < 2000) begin
         if (!mn_wr) lo_wr++;
         lo_cs++;
         @(negedge clk);
      end
      chk("mn_cs_len", lo_cs, 3);
      chk("mn_wr_len", lo_wr, 1);
      chk("mn_data", mn_data, 8'h5A);

      // maximum timing: 765-clock write, 255 clock strobe
      mx_valid = 1'b1; mx_data_i = 8'hA5;
      @(negedge clk);
      mx_valid = 1'b0;
      n = 0;
      while (mx_cs && n < 5) begin
         @(negedge clk);
         n++;
      end
      lo_cs = 0; lo_wr = 0; hold_ok = 1'b1;
      while (!mx_cs && lo_cs < 2000) begin
         if (!mx_wr) lo_wr++;
         if (mx_data !== 8'hA5 || mx_dc !== 1'b1) hold_ok = 1'b0;
         lo_cs++;
         @(negedge clk);
      end
      chk("mx_cs_len", lo_cs, 765);
      chk("mx_wr_len", lo_wr, 255);
      chk("mx_hold", hold_ok, 1'b1);
      chk("mx_busy", mx_busy, 1'b0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
